// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - scans all 16 vectors of a 4-input function and captures its truth table
// Optional comparator against a latched expected table: define SCAN_COMPARE_EN.
module truth_table_scanner #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        f,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [15:0] mismatch,
    output logic [4:0]  err_count
);

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

    // With no settle time each vector goes straight to its sample cycle.
    localparam state_t     VEC_START = (SETTLE == 0) ? SAMPLE : HOLD;
    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] tbl_n, mism_n, sampled, cmp;
    logic [4:0]  err_n;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

`ifdef SCAN_COMPARE_EN
    logic [15:0] exp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
        end else if (state == IDLE && start) begin
            exp_q <= expected;
        end
    end

    assign cmp = sampled ^ exp_q;
`else
    logic unused_expected;

    assign unused_expected = ^expected;
    assign cmp             = 16'h0000;
`endif

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        tbl_n        = truth_table;
        mism_n       = mismatch;
        err_n        = err_count;
        sampled      = truth_table;
        sampled[idx] = f;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_n   = '0;
                    cnt_n   = SETTLE_C;
                    tbl_n   = '0;
                    mism_n  = '0;
                    err_n   = '0;
                    state_n = VEC_START;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                    if (cnt <= 8'd1) begin
                        state_n = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    tbl_n = sampled;
                    if (idx == 4'd15) begin
                        // Comparison uses the table including the bit captured on this edge.
                        mism_n  = cmp;
                        err_n   = popcount16(cmp);
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 4'd1;
                        cnt_n   = SETTLE_C;
                        state_n = VEC_START;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            truth_table <= '0;
            mismatch    <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            truth_table <= tbl_n;
            mismatch    <= mism_n;
            err_count   <= err_n;
        end
    end

    assign {a, b, c, d} = idx;
    assign busy         = (state == HOLD) || (state == SAMPLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - self-checking bench for truth_table_scanner
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, start0, abort0;
    logic [15:0] expected, expected0, func, func0;
    logic        a, b, c, d, busy, done, f;
    logic        a0, b0, c0, d0, busy0, done0, f0;
    logic [15:0] tt, mm, tt0, mm0;
    logic [4:0]  ec, ec0;
    int          total = 0;
    int          bad = 0;

    // The function under test is an arbitrary truth table looked up by the driven vector.
    assign f  = func[{a, b, c, d}];
    assign f0 = func0[{a0, b0, c0, d0}];

    truth_table_scanner #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .f(f), .expected(expected),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
        .truth_table(tt), .mismatch(mm), .err_count(ec)
    );

    truth_table_scanner #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .f(f0), .expected(expected0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .truth_table(tt0), .mismatch(mm0), .err_count(ec0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_mm(input logic [15:0] fn, input logic [15:0] ev);
`ifdef SCAN_COMPARE_EN
        return fn ^ ev;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [4:0] model_err(input logic [15:0] fn, input logic [15:0] ev);
        return 5'($countones(model_mm(fn, ev)));
    endfunction

    // Full scan on the SETTLE=2 instance; extra start pulses at cycles s1/s2 must be ignored.
    task automatic scan_main(input logic [15:0] fn, input logic [15:0] ev, input int s1, input int s2);
        int          done_cyc = 0;
        int          done_cnt = 0;
        int          vec_bad = 0;
        logic [15:0] tt_d = '0;
        logic [15:0] mm_d = '0;
        logic [4:0]  ec_d = '0;
        func = fn;
        expected = ev;
        start = 1'b1;
        step();
        start = 1'b0;
        expected = ~ev;
        for (int cy = 1; cy <= 60; cy++) begin
            if (cy <= 48 && ({a, b, c, d} !== 4'((cy - 1) / 3) || busy !== 1'b1)) vec_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cy;
                    tt_d = tt;
                    mm_d = mm;
                    ec_d = ec;
                end
            end
            start = (cy == s1) || (cy == s2);
            step();
        end
        start = 1'b0;
        check("vector_sequence", 64'(vec_bad), 64'd0);
        check("done_cycle", 64'(done_cyc), 64'd49);
        check("done_count", 64'(done_cnt), 64'd1);
        check("table", 64'(tt_d), 64'(fn));
        check("mismatch", 64'(mm_d), 64'(model_mm(fn, ev)));
        check("err_count", 64'(ec_d), 64'(model_err(fn, ev)));
        check("idle_hold", 64'({busy, tt, mm}), 64'({1'b0, fn, model_mm(fn, ev)}));
    endtask

    initial begin
        logic [15:0] fn, ev;
        int          dn;
        int          vbad;
        int          dcyc;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        expected = '0;
        expected0 = '0;
        func = '0;
        func0 = '0;
        step();
        step();
        check("reset_outputs", 64'({a, b, c, d, busy, done, tt, mm, ec}), 64'd0);
        rst = 1'b0;
        step();

        scan_main(16'h6996, 16'h6996, 0, 0);
        scan_main(16'h6996, 16'h6997, 0, 0);
        scan_main(16'($urandom), 16'($urandom), 5, 20);
        for (int k = 0; k < 3; k++) begin
            scan_main(16'($urandom), 16'($urandom), 0, 0);
        end

        // Abort while vector 0101 is presented.
        fn = 16'($urandom);
        func = fn;
        expected = 16'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && {a, b, c, d} !== 4'd5; i++) step();
        check("abort_reach_vec5", 64'({a, b, c, d}), 64'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) dn++;
            step();
        end
        check("abort_no_done", 64'(dn), 64'd0);
        check("abort_partial", 64'({tt, mm, ec}), 64'({fn & 16'h001F, 16'h0000, 5'd0}));

        // Start with abort in IDLE: start wins, table clears, scan restarts at 0000.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("restart_state", 64'({busy, a, b, c, d, tt}), 64'({1'b1, 4'd0, 16'h0000}));
        for (int i = 0; i < 100 && done !== 1'b1; i++) step();
        check("restart_done", 64'(done), 64'd1);
        check("restart_table", 64'(tt), 64'(fn));
        step();

        // Reset in the middle of vector 1001.
        func = 16'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && {a, b, c, d} !== 4'd9; i++) step();
        check("rst_reach_vec9", 64'({a, b, c, d}), 64'd9);
        rst = 1'b1;
        step();
        check("rst_midscan", 64'({a, b, c, d, busy, done, tt, mm, ec}), 64'd0);
        rst = 1'b0;
        step();
        check("rst_stays_idle", 64'({busy, done}), 64'd0);
        scan_main(16'($urandom), 16'($urandom), 0, 0);

        // SETTLE=0 instance: one vector per cycle.
        for (int k = 0; k < 2; k++) begin
            fn = (k == 0) ? 16'h8000 : 16'($urandom);
            ev = 16'($urandom);
            func0 = fn;
            expected0 = ev;
            start0 = 1'b1;
            step();
            start0 = 1'b0;
            vbad = 0;
            dcyc = 0;
            for (int cy = 1; cy <= 25; cy++) begin
                if (cy <= 16 && {a0, b0, c0, d0} !== 4'(cy - 1)) vbad++;
                if (done0 === 1'b1 && dcyc == 0) begin
                    dcyc = cy;
                    check("s0_table", 64'(tt0), 64'(fn));
                    check("s0_mismatch", 64'({mm0, ec0}), 64'({model_mm(fn, ev), model_err(fn, ev)}));
                end
                step();
            end
            check("s0_vectors", 64'(vbad), 64'd0);
            check("s0_done_cycle", 64'(dcyc), 64'd17);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequencer for one 4-input combinational function under test (inputs a, b, c, d; output f). On a start request it drives all 16 input vectors in ascending order, waits a programmable settle time per vector, samples f, and assembles a 16-bit truth table. An optional comparator checks the table against an expected pattern and counts mismatches. Sits between a control source (bench, switches, or a host FSM) and the combinational datapath, and owns that datapath's inputs.

## Interface
Parameters:
- SETTLE, 2, cycles the vector is held before f is sampled (0..255); each vector occupies SETTLE+1 cycles.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- abort  in  1  cancel the scan in progress; ignored in IDLE.
- f  in  1  output of the function under test.
- expected  in  16  expected truth table; latched when start is accepted (only with SCAN_COMPARE_EN).
- a, b, c, d  out  1 each  registered vector; {a,b,c,d} = idx, a is MSB.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan completes normally.
- table  out  16  captured f values; table[i] = f sampled while {a,b,c,d} = i.
- mismatch  out  16  table XOR latched expected; valid when done is high, then held.
- err_count  out  5  popcount of mismatch (0..16).

## Operation
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE: busy=0. When start=1, the next edge sets idx=0, table=0, mismatch=0, err_count=0, wait counter=SETTLE, latches expected, sets busy=1, and moves to HOLD (SAMPLE if SETTLE=0).
- HOLD: the counter decrements each cycle. When it reaches 1, the next state is SAMPLE.
- SAMPLE: the edge writes f into table[idx]. If idx=15, go to DONE. Otherwise idx increments, the counter reloads SETTLE, and the next state is HOLD (or SAMPLE again if SETTLE=0).
- DONE: lasts one cycle. done=1, busy=0, and mismatch/err_count are updated from the completed table. Returns to IDLE. a..d hold vector 15.
- idx is 4 bits and never wraps within a scan; the scan ends at 15.
- Outputs hold their values in IDLE until the next accepted start.
- start while busy is ignored. There is no queueing.
- abort at any state other than IDLE: the next edge goes to IDLE with busy=0 and no done pulse. table keeps its partial contents. mismatch and err_count are not updated.
- start and abort asserted together in IDLE: start wins; abort is ignored.
- rst at any time, including mid-scan: at the next edge all outputs are 0 (a..d=0, busy=0, done=0, table=0, mismatch=0, err_count=0), the state is IDLE, and the counter is 0.

## Timing
- Start accepted at edge E0. Vector i is presented from edge E0 + i·(SETTLE+1).
- f for vector i is captured at edge E0 + (i+1)·(SETTLE+1). That gives f SETTLE+1 full cycles of settle after a..d change.
- done is high in the cycle after the edge that captures vector 15. Scan latency is 16·(SETTLE+1)+1 cycles from start acceptance to done.
- busy is high from E0 up to the edge that enters DONE.
- A new start is accepted no earlier than the IDLE cycle following DONE. Back-to-back scans therefore have a period of 16·(SETTLE+1)+2 cycles.
- err_count is computed combinationally from the mismatch vector. It is registered together with mismatch on entry to DONE, so there is no additional latency.

## Configuration
- SCAN_COMPARE_EN defined:
  - expected is latched at start.
  - mismatch and err_count operate as described above.
- SCAN_COMPARE_EN undefined:
  - No expected register and no comparator is synthesised.
  - The expected port remains but is unused.
  - mismatch is tied to 16'h0000 and err_count to 5'd0.
  - All other behaviour and timing are identical.

## Test plan
- Reset, then a scan with SETTLE=2, a bench model f = a^b^c^d, expected=16'h6996, start pulsed for one cycle:
  - a..d step through 0000…1111, with each vector held 3 cycles.
  - done pulses at cycle 49 after start acceptance.
  - table=16'h6996, mismatch=0, err_count=0.
- Same scan with expected=16'h6997 (SCAN_COMPARE_EN defined): table=16'h6996, mismatch=16'h0001, err_count=1. With the macro undefined: mismatch=0, err_count=0.
- start pulsed again at cycles 5 and 20 of a scan in progress: both ignored; exactly one done pulse; timing unchanged.
- abort asserted while {a,b,c,d}=0101: busy drops at the next edge and done never pulses. table bits 0..4 hold the f values captured so far, and bits 5..15 are 0. A subsequent start clears table and rescans from 0000.
- rst asserted mid-scan at vector 1001: at the next edge every output is 0 and the state is IDLE. The next start yields a correct full table.
- SETTLE=0 with f = a&b&c&d: one vector per cycle; done pulses 17 cycles after start acceptance; table=16'h8000.
